// File: rtl/cpu_pkg.sv
// Shared CPU definitions: R-type funct codes for the HI/LO instruction group and
// the state encoding of the EX-stage multiply/divide unit. Also used by the Control unit.
package cpu_pkg;

  localparam logic [5:0] FunctMfhi  = 6'h10;
  localparam logic [5:0] FunctMthi  = 6'h11;
  localparam logic [5:0] FunctMflo  = 6'h12;
  localparam logic [5:0] FunctMtlo  = 6'h13;
  localparam logic [5:0] FunctMult  = 6'h18;
  localparam logic [5:0] FunctMultu = 6'h19;
  localparam logic [5:0] FunctDiv   = 6'h1A;
  localparam logic [5:0] FunctDivu  = 6'h1B;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2
  } hilo_state_e;

  function automatic logic is_hilo_funct(input logic [5:0] f);
    return (f inside {FunctMfhi, FunctMthi, FunctMflo, FunctMtlo,
                      FunctMult, FunctMultu, FunctDiv, FunctDivu});
  endfunction

  // MULT/MULTU/DIV/DIVU occupy 0x18..0x1B.
  function automatic logic is_muldiv_funct(input logic [5:0] f);
    return (f[5:2] == 4'b0110);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// EX-stage HI/LO unit: iterative shift-add multiply and restoring divide (one bit per
// cycle), owner of the HI/LO registers, and source of the HI/LO structural stall.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   op_valid, flush   ID/EX entry live / being bubbled this cycle
//   funct             ID/EX R-type funct field
//   rs_data, rt_data  ID/EX operands
//   stall             hold IF/ID and ID/EX while a HI/LO op waits on an in-flight op
//   busy              multiply or divide in flight
//   hi, lo            HI/LO registers
//   mf_data           MFHI ? hi : lo
module ex_muldiv_unit
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic             flush,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mf_data
);

  localparam int unsigned CntW = $clog2(WIDTH);

  hilo_state_e state_q, state_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;  // negate product / quotient
  logic               neg_rem_q, neg_rem_d;  // remainder takes sign of dividend
  logic               dz_q, dz_d;            // divide by zero
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;          // mul: {partial, multiplier}; div: {rem, quot}
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic live, accept, is_signed, rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [WIDTH:0]     add_a, add_b, add_sum;
  logic [2*WIDTH-1:0] acc_step, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign live    = op_valid & ~flush & is_hilo_funct(funct);
  assign busy    = (state_q != StIdle);
  assign stall   = live & busy;
  assign accept  = live & ~busy;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign mf_data = (funct == FunctMfhi) ? hi_q : lo_q;

  assign is_signed = (funct == FunctMult) || (funct == FunctDiv);
  assign rs_neg    = is_signed & rs_data[WIDTH-1];
  assign rt_neg    = is_signed & rt_data[WIDTH-1];
  assign rs_mag    = rs_neg ? -rs_data : rs_data;
  assign rt_mag    = rt_neg ? -rt_data : rt_data;

  // Shared WIDTH+1 adder: mul adds the multiplicand to the partial product,
  // div subtracts the divisor from the shifted remainder (sum[WIDTH] = borrow).
  always_comb begin
    if (is_div_q) begin
      add_a = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      add_b = ~{1'b0, b_q};
    end else begin
      add_a = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
      add_b = {1'b0, b_q};
    end
    add_sum = add_a + add_b + {{WIDTH{1'b0}}, is_div_q};
  end

  always_comb begin
    if (is_div_q) begin
      if (!add_sum[WIDTH]) acc_step = {add_sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                 acc_step = {add_a[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      if (acc_q[0]) acc_step = {add_sum, acc_q[WIDTH-1:1]};
      else          acc_step = {1'b0, acc_q[2*WIDTH-1:1]};
    end
  end

  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quot_fix = dz_q ? {WIDTH{1'b1}}
                         : (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
  assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    b_d       = b_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_muldiv_funct(funct)) begin
            state_d   = StCalc;
            count_d   = '0;
            is_div_d  = funct[1];
            neg_res_d = rs_neg ^ rt_neg;
            neg_rem_d = rs_neg;
            dz_d      = funct[1] & (rt_data == '0);
            b_d       = rt_mag;
            acc_d     = {{WIDTH{1'b0}}, rs_mag};
          end else if (funct == FunctMthi) begin
            hi_d = rs_data;
          end else if (funct == FunctMtlo) begin
            lo_d = rs_data;
          end
        end
      end
      StCalc: begin
        acc_d   = acc_step;
        count_d = count_q + 1'b1;
        if (count_q == CntW'(WIDTH - 1)) state_d = StFix;
      end
      StFix: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      count_q   <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      b_q       <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed cases plus randomized mul/div
// against a plain-arithmetic HI/LO model.
module tb_ex_muldiv_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic        flush;
  logic [5:0]  funct;
  logic [31:0] rs_data, rt_data;
  logic        stall, busy;
  logic [31:0] hi, lo, mf_data;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  ex_muldiv_unit #(.WIDTH(32)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .flush    (flush),
    .funct    (funct),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .stall    (stall),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo),
    .mf_data  (mf_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Reference result {hi, lo} from the instruction semantics.
  function automatic logic [63:0] model_result(input logic [5:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      FunctMult:  begin qv = sa * sb; return qv; end
      FunctMultu: return {32'b0, a} * {32'b0, b};
      FunctDiv: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb; r = sa % sb; qv = q; rv = r;
        return {rv[31:0], qv[31:0]};
      end
      FunctDivu: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return {model_hi, model_lo};
    endcase
  endfunction

  // Present an op; hold while stalled; returns after the accepting edge (+1).
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int stalls);
    funct = f; rs_data = a; rt_data = b; op_valid = 1'b1;
    stalls = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!stall) break;
      stalls++;
    end
    if (stalls >= 200) check_eq("issue_timeout", 32'(stalls), 32'd0);
    @(posedge clk);
    #1 op_valid = 1'b0;
  endtask

  // Count cycles with busy high; ends at the negedge of the first idle cycle.
  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
  endtask

  task automatic check_mf(input string tag);
    op_valid = 1'b1;
    funct = FunctMfhi; #1 check_eq({tag, "_mfhi"}, mf_data, model_hi);
    funct = FunctMflo; #1 check_eq({tag, "_mflo"}, mf_data, model_lo);
    op_valid = 1'b0;
  endtask

  task automatic run_muldiv(input string tag, input logic [5:0] f, input logic [31:0] a,
                            input logic [31:0] b);
    int st, n;
    logic [63:0] r;
    issue(f, a, b, st);
    wait_idle(n);
    r = model_result(f, a, b);
    model_hi = r[63:32];
    model_lo = r[31:0];
    check_eq({tag, "_busy_cycles"}, 32'(n), 32'd33);
    check_eq({tag, "_hi"}, hi, model_hi);
    check_eq({tag, "_lo"}, lo, model_lo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int st, n;
    logic [63:0] r;
    logic [5:0] ops [4];
    logic [31:0] a, b;
    ops[0] = FunctMult; ops[1] = FunctMultu; ops[2] = FunctDiv; ops[3] = FunctDivu;

    rst = 1'b1; op_valid = 1'b0; flush = 1'b0; funct = '0; rs_data = '0; rt_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_hi", hi, 32'd0);
    check_eq("rst_lo", lo, 32'd0);
    check_eq("rst_mf", mf_data, 32'd0);

    // Directed results
    run_muldiv("mult_7_m3", FunctMult, 32'd7, 32'hFFFF_FFFD);
    run_muldiv("multu_max", FunctMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_muldiv("div_m7_2", FunctDiv, 32'hFFFF_FFF9, 32'd2);
    run_muldiv("div_ovf", FunctDiv, 32'h8000_0000, 32'hFFFF_FFFF);
    run_muldiv("divu_by0", FunctDivu, 32'd7, 32'd0);
    run_muldiv("div_by0_neg", FunctDiv, 32'hFFFF_FF00, 32'd0);
    check_mf("after_div0");

    // Non-HI/LO funct while busy must not stall
    issue(FunctMult, 32'd9, 32'd9, st);
    op_valid = 1'b1; funct = 6'h20;
    @(negedge clk);
    check_eq("other_funct_stall", 32'(stall), 32'd0);
    op_valid = 1'b0;
    wait_idle(n);
    model_hi = 32'd0; model_lo = 32'd81;
    check_eq("mult9_lo", lo, model_lo);

    // MULT 3x5 then MFLO five cycles later
    @(posedge clk); #1;
    issue(FunctMult, 32'd3, 32'd5, st);
    repeat (5) @(posedge clk);
    #1 op_valid = 1'b1; funct = FunctMflo;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
    end
    model_hi = 32'd0; model_lo = 32'd15;
    check_eq("mflo_stall_cycles", 32'(n), 32'd28);
    check_eq("mflo_data", mf_data, 32'd15);
    @(posedge clk); #1 op_valid = 1'b0;

    // Flushed DIV is ignored
    op_valid = 1'b1; flush = 1'b1; funct = FunctDiv; rs_data = 32'd100; rt_data = 32'd3;
    @(negedge clk);
    check_eq("flush_stall", 32'(stall), 32'd0);
    @(posedge clk); #1 op_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check_eq("flush_busy", 32'(busy), 32'd0);
    check_eq("flush_hi", hi, model_hi);
    check_eq("flush_lo", lo, model_lo);

    // Reset during DIVU at count 10
    @(posedge clk); #1;
    issue(FunctDivu, 32'd1000, 32'd7, st);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_hi = '0; model_lo = '0;
    @(negedge clk);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_stall", 32'(stall), 32'd0);
    check_eq("midrst_hi", hi, 32'd0);
    check_eq("midrst_lo", lo, 32'd0);

    // MTHI while idle
    issue(FunctMthi, 32'h1234, 32'd0, st);
    model_hi = 32'h1234;
    @(negedge clk);
    check_eq("mthi_hi", hi, 32'h1234);
    check_eq("mthi_stall", 32'(st), 32'd0);

    // MTLO during MULT: stalls, then overwrites lo
    @(posedge clk); #1;
    issue(FunctMult, 32'h0001_0001, 32'h0003_0003, st);
    repeat (3) @(posedge clk);
    #1;
    issue(FunctMtlo, 32'hABCD, 32'd0, st);
    r = model_result(FunctMult, 32'h0001_0001, 32'h0003_0003);
    model_hi = r[63:32]; model_lo = 32'hABCD;
    @(negedge clk);
    check_eq("mtlo_stall_cycles", 32'(st), 32'd30);
    check_eq("mtlo_busy", 32'(busy), 32'd0);
    check_eq("mtlo_lo", lo, 32'hABCD);
    check_eq("mtlo_hi", hi, model_hi);

    // Randomized mul/div
    for (int k = 0; k < 24; k++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = 32'(($urandom_range(0, 15)));
        default: ;
      endcase
      run_muldiv($sformatf("rand%0d", k), ops[$urandom_range(0, 3)], a, b);
      check_mf($sformatf("rand%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
